// File: rtl/y_pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : y_pc_seq
// Purpose  : Program-counter sequencer that sits between the 4-way next-PC
//            mux and instruction-memory fetch. It registers the mux output as
//            the current PC and returns pc + 4 to mux input a0. It also adds
//            run/stall/halt control and counts retired fetches.
// Ports    : clk       - rising-edge clock
//            reset     - asynchronous, active-high reset
//            pc_next   - next-PC candidate from the mux output
//            sel       - select value the mux uses this cycle
//            en        - start / advance request
//            stall     - hold the PC this cycle
//            halt_req  - request a permanent halt
//            pc        - current PC
//            pc_plus4  - pc + 4 (combinational, wraps mod 2^W)
//            valid     - pc is a live fetch address
//            redirect  - one-cycle pulse after a load that used sel != 0
//            halted    - sequencer is in HALT
//            fetch_cnt - number of PC loads since reset
//            misalign  - sticky misaligned-target flag (PC_ALIGN_CHK_EN only)
// Config   : PC_ALIGN_CHK_EN - when defined, a misaligned pc_next halts the
//            sequencer instead of being loaded.
// Revision : 1.0 - initial release
// ============================================================================
module y_pc_seq #(
    parameter int              W         = 32,
    parameter logic [W-1:0]    RESET_VEC = '0,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     pc_next,
    input  logic [1:0]       sel,
    input  logic             en,
    input  logic             stall,
    input  logic             halt_req,
    output logic [W-1:0]     pc,
    output logic [W-1:0]     pc_plus4,
    output logic             valid,
    output logic             redirect,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
`ifdef PC_ALIGN_CHK_EN
    ,
    output logic             misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [W-1:0]     c_FOUR    = {{(W-3){1'b0}}, 3'b100};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [W-1:0]       pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               redir_q, redir_d;

    // An advance is requested only in RUN, with no halt and no stall pending.
    logic w_advance;
    assign w_advance = (state_q == S_RUN) && !halt_req && !stall && en;

`ifdef PC_ALIGN_CHK_EN
    logic mis_q, mis_d;
    logic w_bad_target;
    assign w_bad_target = (pc_next[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VEC;
            cnt_q   <= '0;
            redir_q <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            redir_q <= redir_d;
`ifdef PC_ALIGN_CHK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        redir_d = 1'b0;     // redirect is a pulse: it drops unless a load sets it
`ifdef PC_ALIGN_CHK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Entering RUN leaves pc at RESET_VEC so it is the first fetch.
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (w_advance) begin
`ifdef PC_ALIGN_CHK_EN
                    if (w_bad_target) begin
                        state_d = S_HALT;
                        mis_d   = 1'b1;
                    end else begin
                        pc_d    = pc_next;
                        cnt_d   = cnt_q + c_CNT_ONE;
                        redir_d = (sel != 2'b00);
                    end
`else
                    pc_d    = pc_next;
                    cnt_d   = cnt_q + c_CNT_ONE;
                    redir_d = (sel != 2'b00);
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + c_FOUR;
    assign valid     = (state_q == S_RUN);
    assign halted    = (state_q == S_HALT);
    assign redirect  = redir_q;
    assign fetch_cnt = cnt_q;
`ifdef PC_ALIGN_CHK_EN
    assign misalign  = mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_y_pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_pc_seq
// Purpose  : Self-checking bench for y_pc_seq. A behavioural model tracks the
//            expected sequencer outputs. A single compare process checks the
//            DUT against the model after every clock edge and reset event.
//            Directed scenarios add literal expectations, and a randomized
//            run follows them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y_pc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic [1:0]  sel;
    logic        en, stall, halt_req;
    logic [31:0] pc, pc_plus4;
    logic        valid, redirect, halted;
    logic [15:0] fetch_cnt;
`ifdef PC_ALIGN_CHK_EN
    logic        misalign;
`endif

    y_pc_seq dut (
        .clk       (clk),
        .reset     (reset),
        .pc_next   (pc_next),
        .sel       (sel),
        .en        (en),
        .stall     (stall),
        .halt_req  (halt_req),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .valid     (valid),
        .redirect  (redirect),
        .halted    (halted),
        .fetch_cnt (fetch_cnt)
`ifdef PC_ALIGN_CHK_EN
        ,
        .misalign  (misalign)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model: running/halted flags plus architectural values.
    logic [31:0] m_pc    = 32'h0;
    int unsigned m_cnt   = 0;
    bit          m_run   = 1'b0;
    bit          m_halt  = 1'b0;
    bit          m_redir = 1'b0;
    bit          m_mis   = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h0; m_cnt = 0; m_run = 0; m_halt = 0; m_redir = 0; m_mis = 0;
        end else begin
            m_redir = 0;
            if (m_halt) begin
                // absorbing
            end else if (!m_run) begin
                if (halt_req) m_halt = 1;
                else if (en)  m_run  = 1;
            end else if (halt_req) begin
                m_run = 0; m_halt = 1;
            end else if (!stall && en) begin
                if (ALIGN_CHK && pc_next[1:0] != 2'b00) begin
                    m_run = 0; m_halt = 1; m_mis = 1;
                end else begin
                    m_pc    = pc_next;
                    m_cnt   = (m_cnt + 1) % 65536;
                    m_redir = (sel != 2'b00);
                end
            end
        end
        #1;
        if (check_en) begin
            chk("pc",        pc,                 m_pc);
            chk("pc_plus4",  pc_plus4,           m_pc + 32'd4);
            chk("valid",     {31'b0, valid},     {31'b0, m_run});
            chk("halted",    {31'b0, halted},    {31'b0, m_halt});
            chk("redirect",  {31'b0, redirect},  {31'b0, m_redir});
            chk("fetch_cnt", {16'b0, fetch_cnt}, m_cnt);
`ifdef PC_ALIGN_CHK_EN
            chk("misalign",  {31'b0, misalign},  {31'b0, m_mis});
`endif
        end
    end

    task automatic step(input logic e, input logic s, input logic h,
                        input logic [1:0] sl, input logic [31:0] pn);
        en = e; stall = s; halt_req = h; sel = sl; pc_next = pn;
        @(negedge clk);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'd0, m_pc + 32'd4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 0; stall = 0; halt_req = 0; sel = 0; pc_next = 0;
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_en = 1'b1;
        chk("rst_pc",     pc, 32'h0);
        chk("rst_valid",  {31'b0, valid}, 32'h0);
        chk("rst_cnt",    {16'b0, fetch_cnt}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        reset = 1'b0;

        // Sequential fetch from RESET_VEC
        step(1, 0, 0, 2'd0, 32'h4);
        chk("first_pc",    pc, 32'h0);
        chk("first_valid", {31'b0, valid}, 32'h1);
        seq(5);
        chk("seq_pc",  pc, 32'd20);
        chk("seq_cnt", {16'b0, fetch_cnt}, 32'd5);

        // Redirect pulse
        step(1, 0, 0, 2'd2, 32'h100);
        chk("redir_pc", pc, 32'h100);
        chk("redir_hi", {31'b0, redirect}, 32'h1);
        seq(1);
        chk("redir_lo", {31'b0, redirect}, 32'h0);

        // Stall then halt (halt beats en)
        step(1, 0, 0, 2'd1, 32'h10);
        chk("pre_stall_cnt", {16'b0, fetch_cnt}, 32'd8);
        step(1, 1, 0, 2'd0, 32'h14);
        step(1, 1, 0, 2'd0, 32'h14);
        chk("stall_pc",  pc, 32'h10);
        chk("stall_cnt", {16'b0, fetch_cnt}, 32'd8);
        step(1, 0, 1, 2'd0, 32'h14);
        chk("halt_valid", {31'b0, valid}, 32'h0);
        chk("halt_flag",  {31'b0, halted}, 32'h1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd1, 32'h200);
        chk("halt_pc", pc, 32'h10);

        // Asynchronous reset mid-run at pc=0x40
        do_reset();
        step(1, 0, 0, 2'd0, 32'h4);
        step(1, 0, 0, 2'd1, 32'h40);
        chk("pre_rst_pc", pc, 32'h40);
        #2 reset = 1'b1;
        #1;
        chk("async_pc",     pc, 32'h0);
        chk("async_valid",  {31'b0, valid}, 32'h0);
        chk("async_cnt",    {16'b0, fetch_cnt}, 32'h0);
        chk("async_halted", {31'b0, halted}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Wrap-around
        step(1, 0, 0, 2'd0, 32'h4);
        step(1, 0, 0, 2'd3, 32'hFFFF_FFFC);
        seq(1);
        chk("wrap_pc",  pc, 32'h0);
        chk("wrap_cnt", {16'b0, fetch_cnt}, 32'd2);

        // Misaligned target
        step(1, 0, 0, 2'd1, 32'h102);
`ifdef PC_ALIGN_CHK_EN
        chk("mis_pc",     pc, 32'h0);
        chk("mis_flag",   {31'b0, misalign}, 32'h1);
        chk("mis_halted", {31'b0, halted}, 32'h1);
        do_reset();
        chk("mis_clr",    {31'b0, misalign}, 32'h0);
        chk("mis_hclr",   {31'b0, halted}, 32'h0);
`else
        chk("mis_pc",  pc, 32'h102);
        chk("mis_cnt", {16'b0, fetch_cnt}, 32'd3);
        do_reset();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  sl;
            logic [31:0] pn;
            reset = ($urandom_range(99) < 2);
            sl = 2'($urandom_range(3));
            if (sl == 2'd0)                   pn = m_pc + 32'd4;
            else if ($urandom_range(9) == 0)  pn = $urandom();
            else                              pn = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(9) < 8, $urandom_range(4) == 0,
                 $urandom_range(99) < 3, sl, pn);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
